// File: rtl/team_09_en_sequencer.sv
// team_09_en_sequencer: orders core reset release and pad hand-over around the project enable.
module team_09_en_sequencer #(
  parameter int NUM_IO        = 34,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              en,
  input  logic [NUM_IO-1:0] design_oeb_i,
  input  logic [NUM_IO-1:0] design_out_i,
  output logic [NUM_IO-1:0] gpio_oeb_o,
  output logic [NUM_IO-1:0] gpio_out_o,
  output logic              design_nrst_o,
  output logic              running_o,
  output logic              busy_o,
  output logic [2:0]        state_o
);
  localparam int MAXC = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    RST_HOLD = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    QUIESCE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          run;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= OFF;
      cnt           <= '0;
      design_nrst_o <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      design_nrst_o <= state_n inside {RELEASE, RUN, QUIESCE};
    end
  end

  // Enable loss always wins over the counter; QUIESCE alone ignores en so it is never cut short.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      OFF: if (en) begin
        state_n = RST_HOLD;
        cnt_n   = RST_LOAD;
      end
      RST_HOLD: begin
        state_n = !en ? OFF : cnt == '0 ? RELEASE : RST_HOLD;
        cnt_n   = !en ? '0 : cnt == '0 ? SETTLE_LOAD : cnt - 1'b1;
      end
      RELEASE: begin
        state_n = !en ? QUIESCE : cnt == '0 ? RUN : RELEASE;
        cnt_n   = !en ? SETTLE_LOAD : cnt == '0 ? '0 : cnt - 1'b1;
      end
      RUN: if (!en) begin
        state_n = QUIESCE;
        cnt_n   = SETTLE_LOAD;
      end
      QUIESCE: begin
        state_n = cnt == '0 ? OFF : QUIESCE;
        cnt_n   = cnt == '0 ? '0 : cnt - 1'b1;
      end
      default: begin
        state_n = OFF;
        cnt_n   = '0;
      end
    endcase
  end

  assign run        = state == RUN;
  assign gpio_oeb_o = run ? design_oeb_i : {NUM_IO{1'b1}};
  assign gpio_out_o = run ? design_out_i : {NUM_IO{1'b0}};
  assign running_o  = run;
  assign busy_o     = state inside {RST_HOLD, RELEASE, QUIESCE};
  assign state_o    = state;
endmodule

// File: tb/tb_team_09_en_sequencer.sv
// tb_team_09_en_sequencer: table-driven enable sequences plus async-reset and pad-mirroring checks.
module tb_team_09_en_sequencer;
  localparam int N = 34;
  logic clk = 1'b0, nRst = 1'b0, en = 1'b0;
  logic [N-1:0] design_oeb_i, design_out_i, gpio_oeb_o, gpio_out_o;
  logic design_nrst_o, running_o, busy_o;
  logic [2:0] state_o;
  int total = 0, bad = 0, hi = 0, step_n = 0;

  typedef struct {
    logic       en;
    logic [2:0] st;
    logic       nrst;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  team_09_en_sequencer dut (
    .clk(clk), .nRst(nRst), .en(en),
    .design_oeb_i(design_oeb_i), .design_out_i(design_out_i),
    .gpio_oeb_o(gpio_oeb_o), .gpio_out_o(gpio_out_o),
    .design_nrst_o(design_nrst_o), .running_o(running_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step_n, act, exp);
    end
  endtask

  task automatic check_state(input logic [2:0] st, input logic nrst);
    logic r;
    logic [N-1:0] e_oeb, e_out;
    r     = st == 3'd3;
    e_oeb = r ? design_oeb_i : {N{1'b1}};
    e_out = r ? design_out_i : {N{1'b0}};
    chk("state", 64'(state_o), 64'(st));
    chk("nrst", 64'(design_nrst_o), 64'(nrst));
    chk("running", 64'(running_o), 64'(r));
    chk("busy", 64'(busy_o), 64'(st == 3'd1 || st == 3'd2 || st == 3'd4));
    chk("oeb", 64'(gpio_oeb_o), 64'(e_oeb));
    chk("out", 64'(gpio_out_o), 64'(e_out));
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    step_n++;
    hi = design_nrst_o ? hi + 1 : 0;
    chk("invariant", 64'((gpio_oeb_o == {N{1'b1}}) || (state_o == 3'd3 && hi >= 4)), 64'd1);
  endtask

  function automatic void add(input logic e, input logic [2:0] s, input logic n);
    vq.push_back('{en: e, st: s, nrst: n});
  endfunction

  function automatic logic [2:0] up_st(input int i);
    return i < 16 ? 3'd1 : i < 20 ? 3'd2 : 3'd3;
  endfunction

  initial begin
    design_oeb_i = 34'h0_0000_00F0;
    design_out_i = 34'h2_AAAA_5555;
    // full bring-up then shutdown
    for (int i = 0; i < 25; i++) add(1'b1, up_st(i), i >= 16);
    for (int i = 0; i < 4; i++) add(1'b0, 3'd4, 1'b1);
    add(1'b0, 3'd0, 1'b0); add(1'b0, 3'd0, 1'b0);
    // one-cycle glitch
    add(1'b1, 3'd1, 1'b0); add(1'b0, 3'd0, 1'b0); add(1'b0, 3'd0, 1'b0);
    // abort in RST_HOLD after 5 cycles
    for (int i = 0; i < 5; i++) add(1'b1, 3'd1, 1'b0);
    add(1'b0, 3'd0, 1'b0); add(1'b0, 3'd0, 1'b0);
    // drop en at RELEASE count 2
    for (int i = 0; i < 18; i++) add(1'b1, up_st(i), i >= 16);
    for (int i = 0; i < 4; i++) add(1'b0, 3'd4, 1'b1);
    add(1'b0, 3'd0, 1'b0);
    // en re-raised during QUIESCE
    for (int i = 0; i < 21; i++) add(1'b1, up_st(i), i >= 16);
    add(1'b0, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b1, 3'd4, 1'b1);
    add(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 16; i++) add(1'b1, 3'd1, 1'b0);
    add(1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 3'd4, 1'b1);
    add(1'b0, 3'd0, 1'b0);

    en = 1'b1;
    #12;
    check_state(3'd0, 1'b0);
    en = 1'b0;
    #10 nRst = 1'b1;
    step(1'b0);
    check_state(3'd0, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].en);
      check_state(vq[i].st, vq[i].nrst);
    end

    // RUN: pads follow the core combinationally, then async reset mid-cycle
    for (int i = 0; i < 21; i++) step(1'b1);
    check_state(3'd3, 1'b1);
    design_oeb_i = 34'h3_0000_000F;
    design_out_i = 34'h1_2345_6789;
    #1;
    chk("oeb_mirror", 64'(gpio_oeb_o), 64'(34'h3_0000_000F));
    chk("out_mirror", 64'(gpio_out_o), 64'(34'h1_2345_6789));
    #2 nRst = 1'b0;
    #1;
    check_state(3'd0, 1'b0);
    #2 nRst = 1'b1;
    hi = 0;
    step(1'b0);
    check_state(3'd0, 1'b0);
    step(1'b0);
    check_state(3'd0, 1'b0);
    step(1'b1);
    check_state(3'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
